// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions for the receive word aligner, and later for the
// TMDS encoder and decoder.
//   SYMBOL_W / NUM_OFFSETS  : symbol width and number of candidate bit offsets
//   CTRL_TOKEN_xx           : the four 10-bit TMDS control tokens (C1,C0 = xx)
//   state_t                 : word-aligner state (SEARCH / LOCKED)
//   is_ctrl_token()         : true when a symbol is any control token
// -----------------------------------------------------------------------------
package tmds_pkg;

    localparam int SYMBOL_W    = 10;
    localparam int NUM_OFFSETS = 10;

    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic is_ctrl_token(input logic [SYMBOL_W-1:0] sym);
        return (sym == CTRL_TOKEN_00) || (sym == CTRL_TOKEN_01) ||
               (sym == CTRL_TOKEN_10) || (sym == CTRL_TOKEN_11);
    endfunction

endpackage

// File: rtl/tmds_window_select.sv
// -----------------------------------------------------------------------------
// tmds_window_select
// Combinational 10-bit window extraction from two consecutive deserialized
// words, plus control-token detection on the extracted window.
//   cat    [19:0] : {current word, previous word}; bit 0 is earliest on wire
//   offset [3:0]  : bit offset of the window inside cat (0..9)
//   win    [9:0]  : cat[offset +: 10]
//   tok           : win is one of the four TMDS control tokens
// -----------------------------------------------------------------------------
module tmds_window_select
    import tmds_pkg::*;
(
    input  logic [2*SYMBOL_W-1:0] cat,
    input  logic [3:0]            offset,
    output logic [SYMBOL_W-1:0]   win,
    output logic                  tok
);

    // A right shift keeps the select in range for any offset encoding; only
    // 0..9 are ever applied, for which it equals cat[offset +: 10].
    assign win = SYMBOL_W'(cat >> offset);
    assign tok = is_ctrl_token(win);

endmodule

// File: rtl/tmds_word_aligner.sv
// -----------------------------------------------------------------------------
// tmds_word_aligner
// Finds the TMDS word boundary in a raw 1:10 deserialized stream by hunting
// for runs of control tokens at each of the 10 bit offsets, then holds that
// offset until control tokens stop arriving for LOSS_TIMEOUT cycles.
//   i_clk          : parallel (pixel) clock
//   i_rst          : synchronous, active-high reset
//   i_data   [9:0] : raw deserialized word, bit 0 received first
//   o_data   [9:0] : aligned symbol, one cycle after the completing word
//   o_locked       : high while alignment is locked
//   o_offset [3:0] : bit offset currently applied (0..9)
// -----------------------------------------------------------------------------
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN       = 8,     // consecutive tokens to lock (2..255)
    parameter int SEARCH_TIMEOUT = 128,   // dwell per offset while searching
    parameter int LOSS_TIMEOUT   = 4096   // token-free cycles before unlock
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [SYMBOL_W-1:0] i_data,
    output logic [SYMBOL_W-1:0] o_data,
    output logic                o_locked,
    output logic [3:0]          o_offset
);

    localparam int RUN_W  = $clog2(LOCK_RUN);
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT);
    localparam int IDLE_W = $clog2(LOSS_TIMEOUT);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_RUN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOSS_TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic [SYMBOL_W-1:0] prev;
    logic [SYMBOL_W-1:0] win;
    logic                tok;

    logic [RUN_W-1:0]    run_cnt;
    logic [RUN_W-1:0]    run_next;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [TMO_W-1:0]    tmo_next;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_next;
    logic [3:0]          offset_next;
    logic                locked_next;

    logic                lock_hit;
    logic                search_tmo;
    logic                loss_hit;

    // The previous word sits in the low half: it holds the earlier bits.
    tmds_window_select u_window_select (
        .cat    ({i_data, prev}),
        .offset (o_offset),
        .win    (win),
        .tok    (tok)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path can leave it unassigned and infer a latch.
        state_next = state;
        lock_hit   = 1'b0;
        search_tmo = 1'b0;
        loss_hit   = 1'b0;

        case (state)
            SEARCH: begin
                lock_hit   = tok && (run_cnt == RUN_LAST);
                // Lock wins over the dwell timeout in the same cycle.
                search_tmo = !lock_hit && (tmo_cnt == TMO_LAST);
                if (lock_hit) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                loss_hit = !tok && (idle_cnt == IDLE_LAST);
                if (loss_hit) begin
                    state_next = SEARCH;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counter / offset / flag update logic
    // -------------------------------------------------------------------------
    always_comb begin
        run_next    = run_cnt;
        tmo_next    = tmo_cnt;
        idle_next   = idle_cnt;
        offset_next = o_offset;
        locked_next = (state_next == LOCKED);

        case (state)
            SEARCH: begin
                if (lock_hit) begin
                    run_next  = '0;
                    tmo_next  = '0;
                    idle_next = '0;
                end else if (search_tmo) begin
                    offset_next = (o_offset == 4'(NUM_OFFSETS - 1)) ? 4'd0
                                                                    : o_offset + 4'd1;
                    run_next    = '0;
                    tmo_next    = '0;
                end else begin
                    run_next = tok ? run_cnt + 1'b1 : '0;
                    tmo_next = tmo_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (loss_hit) begin
                    // Offset is kept so the search resumes from the last lock.
                    run_next  = '0;
                    tmo_next  = '0;
                    idle_next = '0;
                end else if (tok) begin
                    idle_next = '0;
                end else begin
                    idle_next = idle_cnt + 1'b1;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state    <= SEARCH;
            prev     <= '0;
            o_data   <= '0;
            o_locked <= 1'b0;
            o_offset <= 4'd0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_next;
            prev     <= i_data;
            o_data   <= win;
            o_locked <= locked_next;
            o_offset <= offset_next;
            run_cnt  <= run_next;
            tmo_cnt  <= tmo_next;
            idle_cnt <= idle_next;
        end
    end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_tmds_word_aligner
// Scoreboard bench: every applied word pushes the expected post-edge outputs
// from a bit-stream reference model; a monitor pops and compares each cycle.
// Directed phases also measure lock/unlock latencies against fixed numbers.
// -----------------------------------------------------------------------------
module tb_tmds_word_aligner;

    localparam int LOCK_RUN       = 8;
    localparam int SEARCH_TIMEOUT = 128;
    localparam int LOSS_TIMEOUT   = 4096;

    localparam logic [9:0] TOKEN = 10'b1101010100;
    localparam logic [9:0] DSYM  = 10'b0111110000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] data_in = 10'd0;
    logic [9:0] data_out;
    logic       locked;
    logic [3:0] offset;

    always #5 clk = ~clk;

    tmds_word_aligner #(
        .LOCK_RUN       (LOCK_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_data   (data_in),
        .o_data   (data_out),
        .o_locked (locked),
        .o_offset (offset)
    );

    typedef struct packed {
        logic [9:0] data;
        logic       locked;
        logic [3:0] offset;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [9:0] tok_list [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};

    // ---------------- reference model (bit-stream view) ----------------
    logic [9:0] m_prev   = 10'd0;
    int         m_off    = 0;
    bit         m_locked = 1'b0;
    int         m_run    = 0;
    int         m_tmo    = 0;
    int         m_idle   = 0;
    logic [9:0] sym_prev = 10'd0;
    int         offset_trace[$];

    function automatic bit tb_is_token(logic [9:0] w);
        foreach (tok_list[i]) if (w == tok_list[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Word carrying symbol s at bit phase p; the earlier symbol sp supplies
    // the low p bits, so the window at offset p recovers sp on the next word.
    function automatic logic [9:0] make_word(logic [9:0] s, logic [9:0] sp, int p);
        logic [19:0] t;
        t = ({10'd0, s} << p) | ({10'd0, sp} >> (10 - p));
        return t[9:0];
    endfunction

    task automatic model_step(input bit r, input logic [9:0] d);
        exp_t        e;
        logic [19:0] cat;
        logic [9:0]  w;
        bit          t;
        if (r) begin
            m_off = 0; m_locked = 1'b0; m_run = 0; m_tmo = 0; m_idle = 0;
            e = '{data: 10'd0, locked: 1'b0, offset: 4'd0};
        end else begin
            cat = {d, m_prev};
            w   = 10'(cat >> m_off);
            t   = tb_is_token(w);
            if (!m_locked) begin
                if (t && m_run == LOCK_RUN - 1) begin
                    m_locked = 1'b1; m_run = 0; m_tmo = 0; m_idle = 0;
                end else if (m_tmo == SEARCH_TIMEOUT - 1) begin
                    m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0;
                end else begin
                    m_run = t ? m_run + 1 : 0;
                    m_tmo = m_tmo + 1;
                end
            end else begin
                if (t) m_idle = 0;
                else if (m_idle == LOSS_TIMEOUT - 1) begin
                    m_locked = 1'b0; m_run = 0; m_tmo = 0; m_idle = 0;
                end else m_idle = m_idle + 1;
            end
            e = '{data: w, locked: m_locked, offset: 4'(m_off)};
        end
        m_prev = r ? 10'd0 : d;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit r, input logic [9:0] d);
        @(negedge clk);
        rst     = r;
        data_in = d;
        model_step(r, d);
    endtask

    task automatic send_sym(input logic [9:0] s, input int p);
        step(1'b0, make_word(s, sym_prev, p));
        sym_prev = s;
    endtask

    task automatic do_reset();
        step(1'b1, 10'd0);
        sym_prev = 10'd0;
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Feeds symbol s at phase p until the DUT reports lock; n = edges used.
    task automatic feed_until_lock(input logic [9:0] s, input int p,
                                   input int limit, output int n);
        int last_off;
        n = 0;
        last_off = int'(offset);
        offset_trace.delete();
        do begin
            send_sym(s, p);
            n++;
            @(posedge clk); #1;
            if (int'(offset) != last_off) begin
                offset_trace.push_back(int'(offset));
                last_off = int'(offset);
            end
        end while (!locked && n < limit);
    endtask

    task automatic feed_until_unlock(input logic [9:0] s, input int p,
                                     input int limit, output int n);
        n = 0;
        do begin
            send_sym(s, p);
            n++;
            @(posedge clk); #1;
        end while (locked && n < limit);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge clk); #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({data_out, locked, offset} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard: got data=%b locked=%b offset=%0d, want data=%b locked=%b offset=%0d",
                             data_out, locked, offset, e.data, e.locked, e.offset);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        int want_trace[5] = '{8, 9, 0, 1, 2};

        // Aligned tokens: first window after reset holds the cleared previous
        // word, so the 8th token window arrives on edge 9.
        do_reset();
        feed_until_lock(TOKEN, 0, 50, n);
        check("lock_latency_off0", n, 9);
        check("lock_offset_off0", int'(offset), 0);
        repeat (5) send_sym(TOKEN, 0);

        // Loss: first data word enters the window one edge late (offset 0 is
        // the previous word), then 4096 token-free windows drop lock.
        feed_until_unlock(DSYM, 0, 5000, n);
        check("loss_latency", n, LOSS_TIMEOUT + 1);
        check("loss_offset_kept", int'(offset), 0);

        // Stream shifted by 3: three full dwells, then 8 tokens at offset 3.
        do_reset();
        feed_until_lock(TOKEN, 3, 600, n);
        check("lock_latency_off3", n, 3 * SEARCH_TIMEOUT + LOCK_RUN);
        check("lock_offset_off3", int'(offset), 3);
        repeat (4) send_sym(TOKEN, 3);

        // 8th token window on edge 128 (tmo_cnt == 127): lock, no advance.
        do_reset();
        repeat (119) send_sym(10'd0, 0);
        feed_until_lock(TOKEN, 0, 50, n);
        check("lock_on_timeout_edge", n, 9);
        check("lock_on_timeout_offset", int'(offset), 0);

        // Lock at 7, realign to 2, search wraps 7,8,9,0,1,2.
        do_reset();
        feed_until_lock(TOKEN, 7, 1200, n);
        check("lock_latency_off7", n, 7 * SEARCH_TIMEOUT + LOCK_RUN);
        feed_until_unlock(TOKEN, 2, 5000, n);
        check("realign_unlock_seen", int'(n < 5000), 1);
        feed_until_lock(TOKEN, 2, 1200, n);
        check("relock_latency_off2", n, 5 * SEARCH_TIMEOUT + LOCK_RUN);
        check("relock_offset_off2", int'(offset), 2);
        check("search_trace_len", offset_trace.size(), 5);
        foreach (want_trace[i])
            if (i < offset_trace.size())
                check("search_trace_step", offset_trace[i], want_trace[i]);

        // Reset pulse while locked at 5.
        do_reset();
        feed_until_lock(TOKEN, 5, 1000, n);
        check("lock_latency_off5", n, 5 * SEARCH_TIMEOUT + LOCK_RUN);
        step(1'b1, make_word(TOKEN, TOKEN, 5));
        sym_prev = 10'd0;
        @(posedge clk); #1;
        check("rst_pulse_locked", int'(locked), 0);
        check("rst_pulse_offset", int'(offset), 0);
        check("rst_pulse_data", int'(data_out), 0);
        feed_until_lock(TOKEN, 5, 1000, n);
        check("relock_after_rst", n, 5 * SEARCH_TIMEOUT + LOCK_RUN);

        // Random token mix with occasional noise at random phases.
        repeat (2) begin
            int p;
            logic [9:0] s;
            p = int'($urandom_range(0, 9));
            do_reset();
            repeat (1500) begin
                if ($urandom_range(0, 15) == 0) s = 10'($urandom);
                else s = tok_list[$urandom_range(0, 3)];
                send_sym(s, p);
            end
        end

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
